// File: rtl/thumb_decode_queue_pkg.sv
// thumb_decode_queue_pkg: decoded-op types, opcode prefixes and small helpers for the Thumb decode queue
package thumb_decode_queue_pkg;
  localparam int NUM_W = 32;
  localparam int SEL_W = 4;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NONE = 4'b1111;
  localparam logic [4:0] OP_ADDSUB = 5'b00011;
  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_IMM8 = 3'b001;
  localparam logic [9:0] OP_EOR = 10'b0100000001;
  localparam logic [4:0] OP_STR_IMM = 5'b01100;
  localparam logic [4:0] OP_LDR_IMM = 5'b01101;
  localparam logic [3:0] OP_BCOND = 4'b1101;
  localparam logic [4:0] OP_B = 5'b11100;
  localparam logic [4:0] OP_BL_HI = 5'b11110;
  localparam logic [4:0] OP_BL_LO = 5'b11111;
  typedef enum logic [3:0] {
    UOP_NOP, UOP_ADD, UOP_SUB, UOP_MOV, UOP_CMP, UOP_EOR, UOP_LSL, UOP_LDR, UOP_STR
  } uop_t;
  typedef struct packed {
    uop_t uop;
    logic num_to_rhs;
    logic [NUM_W-1:0] num;
    logic [SEL_W-1:0] sel_p0;
    logic [SEL_W-1:0] sel_p1;
    logic [SEL_W-1:0] sel_in;
    logic [3:0] branch_cond;
    logic link;
    logic undef;
  } decoded_op_t;
  localparam decoded_op_t OP_RESET = '{uop: UOP_NOP, num_to_rhs: 1'b0, num: '0, sel_p0: '0,
    sel_p1: '0, sel_in: '0, branch_cond: COND_NONE, link: 1'b0, undef: 1'b0};
  function automatic logic [SEL_W-1:0] reg_sel(input logic [2:0] r);
    return {{(SEL_W-3){1'b0}}, r};
  endfunction
  function automatic logic [NUM_W-1:0] sext8(input logic [7:0] v);
    return {{(NUM_W-8){v[7]}}, v};
  endfunction
  function automatic logic [NUM_W-1:0] sext11(input logic [10:0] v);
    return {{(NUM_W-11){v[10]}}, v};
  endfunction
  function automatic logic [NUM_W-1:0] sext22(input logic [21:0] v);
    return {{(NUM_W-22){v[21]}}, v};
  endfunction
endpackage

// File: rtl/thumb_decode_queue_if.sv
// thumb_decode_queue_if: fetch-side and execute-side handshakes plus flush for the decode queue
interface thumb_decode_queue_if;
  import thumb_decode_queue_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [15:0] instruction;
  logic out_valid;
  logic out_ready;
  decoded_op_t out_op;
  modport master(output flush, in_valid, instruction, out_ready, input in_ready, out_valid, out_op);
  modport slave(input flush, in_valid, instruction, out_ready, output in_ready, out_valid, out_op);
endinterface

// File: rtl/thumb_decode_queue_comb.sv
// thumb_decode_comb: purely combinational Thumb-1 halfword to decoded-op table
module thumb_decode_comb
  import thumb_decode_queue_pkg::*;
(
  input  logic [15:0]  instruction,
  output decoded_op_t  op
);
  logic [15:0] ins;
  assign ins = instruction;
  always_comb begin
    op = OP_RESET;
    if (ins[15:11] == OP_ADDSUB) begin
      op.uop = ins[9] ? UOP_SUB : UOP_ADD;
      op.sel_p1 = reg_sel(ins[5:3]);
      op.sel_in = reg_sel(ins[2:0]);
      op.num_to_rhs = ins[10];
      op.num = ins[10] ? NUM_W'(ins[8:6]) : '0;
      op.sel_p0 = ins[10] ? '0 : reg_sel(ins[8:6]);
    end else if (ins[15:13] == OP_SHIFT) begin
      op.uop = UOP_LSL;
      op.num = NUM_W'(ins[10:6]);
      op.sel_p1 = reg_sel(ins[5:3]);
      op.sel_in = reg_sel(ins[2:0]);
      op.num_to_rhs = 1'b1;
    end else if (ins[15:13] == OP_IMM8) begin
      // MOV writes rd only, CMP reads it only, ADD/SUB read and write it
      op.uop = ins[12] ? (ins[11] ? UOP_SUB : UOP_ADD) : (ins[11] ? UOP_CMP : UOP_MOV);
      op.num = NUM_W'(ins[7:0]);
      op.num_to_rhs = 1'b1;
      op.sel_in = (ins[12:11] == 2'b01) ? '0 : reg_sel(ins[10:8]);
      op.sel_p1 = (ins[12:11] == 2'b00) ? '0 : reg_sel(ins[10:8]);
    end else if (ins[15:6] == OP_EOR) begin
      op.uop = UOP_EOR;
      op.sel_p0 = reg_sel(ins[2:0]);
      op.sel_in = reg_sel(ins[2:0]);
      op.sel_p1 = reg_sel(ins[5:3]);
    end else if (ins[15:11] == OP_LDR_IMM || ins[15:11] == OP_STR_IMM) begin
      op.uop = ins[11] ? UOP_LDR : UOP_STR;
      op.num = NUM_W'(ins[10:6]);
      op.sel_p1 = reg_sel(ins[5:3]);
      op.num_to_rhs = 1'b1;
      op.sel_in = ins[11] ? reg_sel(ins[2:0]) : '0;
      op.sel_p0 = ins[11] ? '0 : reg_sel(ins[2:0]);
    end else if (ins[15:12] == OP_BCOND) begin
      op.branch_cond = ins[11:8];
      op.num = sext8(ins[7:0]);
      op.undef = &ins[11:9];
    end else if (ins[15:11] == OP_B) begin
      op.branch_cond = COND_AL;
      op.num = sext11(ins[10:0]);
    end else begin
      op.undef = 1'b1;
    end
  end
endmodule

// File: rtl/thumb_decode_queue.sv
// thumb_decode_queue: Thumb-1 decode stage with BL prefix/suffix FSM and a DEPTH-entry decoded-op FIFO
module thumb_decode_queue
  import thumb_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  thumb_decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef enum logic {IDLE, PREFIX} state_t;
  state_t state, state_n;
  logic [10:0] hi;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  decoded_op_t mem [DEPTH];
  decoded_op_t dec_op, push_op;
  logic full, is_suffix, is_prefix, orphan, accept, push, pop, latch_hi;
  thumb_decode_comb u_dec (.instruction(bus.instruction), .op(dec_op));
  assign full = count == (PTR_W+1)'(DEPTH);
  assign is_prefix = bus.instruction[15:11] == OP_BL_HI;
  assign is_suffix = bus.instruction[15:11] == OP_BL_LO;
  // A non-suffix after a prefix is stalled one cycle while the orphan is reported
  assign orphan = state == PREFIX && bus.in_valid && !is_suffix;
  assign bus.in_ready = reset && !full && !bus.flush && !orphan;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = count != '0;
  assign bus.out_op = bus.out_valid ? mem[rd_ptr] : OP_RESET;
  assign pop = bus.out_valid && bus.out_ready && !bus.flush;
  always_comb begin
    state_n = state;
    push = 1'b0;
    push_op = dec_op;
    latch_hi = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      latch_hi = accept && is_prefix;
      push = accept && !is_prefix;
      state_n = latch_hi ? PREFIX : IDLE;
    end else if (orphan) begin
      push = !full;
      push_op = OP_RESET;
      push_op.undef = 1'b1;
      state_n = full ? PREFIX : IDLE;
    end else if (accept) begin
      push = 1'b1;
      push_op = OP_RESET;
      push_op.branch_cond = COND_AL;
      push_op.link = 1'b1;
      push_op.num = sext22({hi, bus.instruction[10:0]});
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (latch_hi) hi <= bus.instruction[10:0];
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_op;
endmodule

// File: tb/tb_thumb_decode_queue.sv
// tb_thumb_decode_queue: scoreboard bench for the Thumb decode queue
module tb_thumb_decode_queue;
  import thumb_decode_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int st;
  decoded_op_t sb[$];
  decoded_op_t mon_exp;
  decoded_op_t first_op;
  always #5 clk = ~clk;
  thumb_decode_queue_if bus();
  thumb_decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic decoded_op_t mk(input uop_t u, input logic rhs, input logic [31:0] num,
      input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] rin,
      input logic [3:0] cond, input logic link, input logic undef);
    mk = '{u, rhs, num, p0, p1, rin, cond, link, undef};
  endfunction

  function automatic decoded_op_t undef_op();
    return mk(UOP_NOP, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, COND_NONE, 1'b0, 1'b1);
  endfunction

  task automatic send(input logic [15:0] ins, output int stalls);
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.instruction = ins;
    @(negedge clk);
    while (!bus.in_ready && stalls < 64) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 64) check("accept_timeout", 64'(stalls), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_send(input logic [15:0] ins, input decoded_op_t exp);
    int s;
    sb.push_back(exp);
    send(ins, s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        mon_exp = sb.pop_front();
        check("head", 64'(bus.out_op), 64'(mon_exp));
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instruction = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_op", 64'(bus.out_op), 64'(OP_RESET));
    idle(2);
    reset = 1'b1;
    idle(1);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    // MOVS r3,#0x5A
    push_send(16'h235A, mk(UOP_MOV, 1'b1, 32'h5A, 4'd0, 4'd0, 4'd3, COND_NONE, 1'b0, 1'b0));
    check("movs_valid", 64'(bus.out_valid), 64'd1);
    check("movs_head", 64'(bus.out_op), 64'(mk(UOP_MOV, 1'b1, 32'h5A, 4'd0, 4'd0, 4'd3, COND_NONE, 1'b0, 1'b0)));
    bus.out_ready = 1'b1;
    idle(2);
    push_send(16'h1C4A, mk(UOP_ADD, 1'b1, 32'd1, 4'd0, 4'd1, 4'd2, COND_NONE, 1'b0, 1'b0));
    push_send(16'h1A8B, mk(UOP_SUB, 1'b0, 32'd0, 4'd2, 4'd1, 4'd3, COND_NONE, 1'b0, 1'b0));
    push_send(16'h0088, mk(UOP_LSL, 1'b1, 32'd2, 4'd0, 4'd1, 4'd0, COND_NONE, 1'b0, 1'b0));
    push_send(16'h2A10, mk(UOP_CMP, 1'b1, 32'h10, 4'd0, 4'd2, 4'd0, COND_NONE, 1'b0, 1'b0));
    push_send(16'h3105, mk(UOP_ADD, 1'b1, 32'd5, 4'd0, 4'd1, 4'd1, COND_NONE, 1'b0, 1'b0));
    push_send(16'h3E01, mk(UOP_SUB, 1'b1, 32'd1, 4'd0, 4'd6, 4'd6, COND_NONE, 1'b0, 1'b0));
    push_send(16'h404A, mk(UOP_EOR, 1'b0, 32'd0, 4'd2, 4'd1, 4'd2, COND_NONE, 1'b0, 1'b0));
    push_send(16'h6888, mk(UOP_LDR, 1'b1, 32'd2, 4'd0, 4'd1, 4'd0, COND_NONE, 1'b0, 1'b0));
    push_send(16'h6011, mk(UOP_STR, 1'b1, 32'd0, 4'd1, 4'd2, 4'd0, COND_NONE, 1'b0, 1'b0));
    push_send(16'hD1FE, mk(UOP_NOP, 1'b0, 32'hFFFF_FFFE, 4'd0, 4'd0, 4'd0, 4'b0001, 1'b0, 1'b0));
    push_send(16'hDE00, mk(UOP_NOP, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 1'b0, 1'b1));
    push_send(16'hE7FF, mk(UOP_NOP, 1'b0, 32'hFFFF_FFFF, 4'd0, 4'd0, 4'd0, COND_AL, 1'b0, 1'b0));
    push_send(16'hB000, undef_op());
    idle(3);
    // BL: prefix alone produces nothing
    sb.push_back(mk(UOP_NOP, 1'b0, 32'd2, 4'd0, 4'd0, 4'd0, COND_AL, 1'b1, 1'b0));
    send(16'hF000, st);
    idle(1);
    check("bl_prefix_no_entry", 64'(bus.out_valid), 64'd0);
    send(16'hF802, st);
    push_send(16'hF7FF, mk(UOP_NOP, 1'b0, 32'hFFFF_F800, 4'd0, 4'd0, 4'd0, COND_AL, 1'b1, 1'b0));
    send(16'hF800, st);
    // Orphan prefix followed by ADDS r0,r1,r2
    sb.push_back(undef_op());
    sb.push_back(mk(UOP_ADD, 1'b0, 32'd0, 4'd2, 4'd1, 4'd0, COND_NONE, 1'b0, 1'b0));
    send(16'hF000, st);
    send(16'h1888, st);
    check("orphan_stall", 64'(st), 64'd1);
    idle(3);
    // Backpressure: fill, then hold one more at the input
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      push_send(16'h2000 + 16'(k), mk(UOP_MOV, 1'b1, 32'(k), 4'd0, 4'd0, 4'd0, COND_NONE, 1'b0, 1'b0));
    first_op = mk(UOP_MOV, 1'b1, 32'd0, 4'd0, 4'd0, 4'd0, COND_NONE, 1'b0, 1'b0);
    sb.push_back(mk(UOP_MOV, 1'b1, 32'h10, 4'd0, 4'd0, 4'd0, COND_NONE, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.instruction = 16'h2010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_head_stable", 64'(bus.out_op), 64'(first_op));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h2010, st);
    check("full_no_bypass", 64'(st), 64'd1);
    idle(DEPTH + 3);
    // Flush with three entries queued and a valid input
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      push_send(16'h2100 + 16'(k), mk(UOP_MOV, 1'b1, 32'(k), 4'd0, 4'd0, 4'd1, COND_NONE, 1'b0, 1'b0));
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.instruction = 16'h2077;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    push_send(16'h2233, mk(UOP_MOV, 1'b1, 32'h33, 4'd0, 4'd0, 4'd2, COND_NONE, 1'b0, 1'b0));
    bus.out_ready = 1'b1;
    idle(1);
    check("flush_count_zero", 64'(bus.out_valid), 64'd0);
    // Async reset mid-prefix with a non-empty FIFO
    bus.out_ready = 1'b0;
    push_send(16'h235A, mk(UOP_MOV, 1'b1, 32'h5A, 4'd0, 4'd0, 4'd3, COND_NONE, 1'b0, 1'b0));
    send(16'hF000, st);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_cond", 64'(bus.out_op.branch_cond), 64'(COND_NONE));
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    push_send(16'hF802, undef_op());
    idle(4);
    check("drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
